pipe_stall_ctrl: RTL and testbench
==================================

// Module: pipe_stall_ctrl
// PURPOSE
//  Central stall/flush controller for the five-stage pipeline. It merges stall
//  requests from IF/ID/EX/MEM into the shared stall[5:0] bus. Every pipeline
//  register (PC, IF_ID, ID_EX, EX_MEM, MEM_WB) consumes that bus.
//  It sequences multi-cycle EX operations (mul/div) with an internal cycle counter.
//  It issues a one-cycle flush with a redirect PC on exceptions, and keeps a
//  saturating stall-cycle performance counter.
// PARAMETERS
//  MC_CNT_W  6   width of multi-cycle length input and internal down-counter
//  PERF_W    32  width of stall-cycle performance counter
// PORTS
//  clk           in   1         system clock, rising edge
//  rst           in   1         asynchronous reset, active-high
//  stallreq_if   in   1         IF waits on instruction memory
//  stallreq_id   in   1         ID load-use hazard
//  stallreq_ex   in   1         EX single-cycle stall request
//  stallreq_mem  in   1         MEM waits on data memory
//  mc_start      in   1         EX begins multi-cycle op (1-cycle pulse)
//  mc_cycles     in   MC_CNT_W  total stall cycles for that op (N)
//  excp_valid    in   1         exception committed in MEM
//  excp_vector   in   32        handler address
//  stall         out  6         [0]PC [1]IF_ID [2]ID_EX [3]EX_MEM [4]MEM_WB [5]WB; 1=hold
//  flush         out  1         clear all pipeline registers this cycle
//  new_pc        out  32        redirect target, valid when flush=1
//  mc_done       out  1         multi-cycle result ready in EX this cycle
//  mc_busy       out  1         state==MC_BUSY
//  stall_cycles  out  PERF_W    count of cycles with stall[0]=1, saturating
// BEHAVIOUR
//  - Reset (rst=1, async): state=IDLE, cnt=0, stall_cycles=0. stall=0, flush=0,
//    new_pc=0, mc_done=0, mc_busy=0 while rst is high. Reset aborts any op.
//  - stall/flush/new_pc/mc_done are combinational from state, cnt and inputs.
//    Pipeline registers sample them at the same posedge. No added latency.
//  - Stall bit i=1 with bit i+1=0 makes register i+1 insert a bubble.
//    Stall priority (highest first):
//    excp_valid -> stall=000000, flush=1, new_pc=excp_vector
//    stallreq_mem -> 011111
//    stallreq_ex | ex_mc -> 001111
//    stallreq_id -> 000111
//    stallreq_if -> 000011
//    otherwise 000000
//  - ex_mc = (IDLE & mc_start & mc_cycles!=0) | (MC_BUSY & cnt!=0).
//  - FSM IDLE:
//    - mc_start & mc_cycles=N!=0 & !excp_valid: cnt<=N-1, go MC_BUSY.
//    - mc_start with mc_cycles=0: ignored; no stall, no mc_done.
//  - FSM MC_BUSY:
//    - cnt!=0: stall requested; cnt<=cnt-1 unless stallreq_mem=1 (counter freezes).
//    - cnt==0: no EX stall from ctrl, mc_done=1, go IDLE.
//      If stallreq_mem=1 in that cycle, hold in MC_BUSY with mc_done=0 until it drops.
//    - Net effect: exactly N stalled cycles, excluding cycles frozen by MEM.
//    - mc_start while MC_BUSY is ignored.
//  - excp_valid in any state: flush=1 for that cycle, state<=IDLE, cnt<=0.
//    mc_done stays 0; the multi-cycle op is aborted.
//    A simultaneous mc_start is ignored. Two consecutive excp cycles give two flushes.
//  - stall_cycles: +1 on each posedge with stall[0]=1, holds at 2^PERF_W-1.
//    Flush cycles do not count.
// TESTING
//  1. Reset mid-MC_BUSY (cnt=5), rst pulse asynchronously -> all outputs 0
//     immediately; state IDLE; stall_cycles=0.
//  2. mc_start, mc_cycles=4 -> stall=001111 for 4 cycles, then 1 cycle with
//     mc_done=1, stall=000000. stall_cycles=4.
//  3. Same as 2, stallreq_mem=1 for 2 cycles during the op -> stall=011111 in
//     those cycles; EX stall lasts 6 cycles total; mc_done exactly once.
//  4. stallreq_id=1 & stallreq_if=1 together -> stall=000111.
//     stallreq_mem=1 added -> 011111.
//  5. MC_BUSY (cnt=3) with excp_valid=1, excp_vector=0x0000_0020 ->
//     flush=1, new_pc=0x20, stall=0 that cycle. Next cycle IDLE, no mc_done.
//  6. mc_start with mc_cycles=0 -> no stall, no mc_done, state stays IDLE.
//     Force stall_cycles near max -> saturates, no wrap.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Merges stage stall requests into the shared stall bus and sequences multi-cycle EX ops.
// Combinational stall/flush outputs (zero latency); flush on exception overrides all stalls.
module pipe_stall_ctrl #(
  parameter int MC_CNT_W = 6,
  parameter int PERF_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_if,
  input  logic                stallreq_id,
  input  logic                stallreq_ex,
  input  logic                stallreq_mem,
  input  logic                mc_start,
  input  logic [MC_CNT_W-1:0] mc_cycles,
  input  logic                excp_valid,
  input  logic [31:0]         excp_vector,
  output logic [5:0]          stall,
  output logic                flush,
  output logic [31:0]         new_pc,
  output logic                mc_done,
  output logic                mc_busy,
  output logic [PERF_W-1:0]   stall_cycles
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] MC_BUSY = 1'b1;
  localparam logic [MC_CNT_W-1:0] CNT_ONE = {{(MC_CNT_W-1){1'b0}}, 1'b1};

  logic [0:0]          state;
  logic [MC_CNT_W-1:0] cnt;
  logic                mc_launch;
  logic                ex_mc;

  assign mc_launch = (state == IDLE) && mc_start && (mc_cycles != '0);
  assign ex_mc     = mc_launch || ((state == MC_BUSY) && (cnt != '0));
  assign mc_busy   = (state == MC_BUSY);

  // Outputs are forced low while reset is asserted, regardless of inputs.
  always_comb begin
    stall   = 6'b000000;
    flush   = 1'b0;
    new_pc  = 32'h0;
    mc_done = 1'b0;
    if (!rst) begin
      if (excp_valid) begin
        flush  = 1'b1;
        new_pc = excp_vector;
      end else if (stallreq_mem) begin
        stall = 6'b011111;
      end else if (stallreq_ex || ex_mc) begin
        stall = 6'b001111;
      end else if (stallreq_id) begin
        stall = 6'b000111;
      end else if (stallreq_if) begin
        stall = 6'b000011;
      end
      mc_done = (state == MC_BUSY) && (cnt == '0) && !stallreq_mem && !excp_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (excp_valid) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mc_launch) begin
            cnt   <= mc_cycles - CNT_ONE;
            state <= MC_BUSY;
          end
        end
        default: begin
          // A MEM stall freezes the op: neither the countdown nor completion advances.
          if (cnt != '0) begin
            if (!stallreq_mem) cnt <= cnt - CNT_ONE;
          end else if (!stallreq_mem) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall[0] && (stall_cycles != {PERF_W{1'b1}})) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Randomized and directed check of pipe_stall_ctrl against an op-level behavioural model.
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic        mc_start;
  logic [5:0]  mc_cycles;
  logic        excp_valid;
  logic [31:0] excp_vector;

  logic [5:0]  stall;
  logic        flush, mc_done, mc_busy;
  logic [31:0] new_pc;
  logic [31:0] stall_cycles;

  logic [5:0]  s_stall;
  logic        s_flush, s_done, s_busy;
  logic [31:0] s_pc;
  logic [3:0]  s_cycles;

  pipe_stall_ctrl #(.MC_CNT_W(6), .PERF_W(32)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .mc_start(mc_start), .mc_cycles(mc_cycles),
    .excp_valid(excp_valid), .excp_vector(excp_vector),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .mc_done(mc_done), .mc_busy(mc_busy), .stall_cycles(stall_cycles)
  );

  // Narrow counter instance so saturation is reachable.
  pipe_stall_ctrl #(.MC_CNT_W(6), .PERF_W(4)) dut_small (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .mc_start(mc_start), .mc_cycles(mc_cycles),
    .excp_valid(excp_valid), .excp_vector(excp_vector),
    .stall(s_stall), .flush(s_flush), .new_pc(s_pc),
    .mc_done(s_done), .mc_busy(s_busy), .stall_cycles(s_cycles)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: an op in flight with a number of EX stall cycles still owed.
  bit      m_op;
  int      m_owed;
  longint  m_perf;

  logic [5:0]  smp_stall;
  logic        smp_done, smp_flush;
  logic [31:0] smp_pc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    mc_start = 0; mc_cycles = 0; excp_valid = 0; excp_vector = 0;
  endtask

  task automatic model_reset();
    m_op = 0; m_owed = 0; m_perf = 0;
  endtask

  // Compare one cycle against the model, then advance the model across the posedge.
  task automatic step();
    logic [5:0]  es;
    logic        ed;
    bit          ex_req;
    longint      sat_small;
    @(negedge clk);
    smp_stall = stall; smp_done = mc_done; smp_flush = flush; smp_pc = new_pc;
    ex_req = stallreq_ex || (!m_op && mc_start && mc_cycles != 0) || (m_op && m_owed > 0);
    if (excp_valid)        es = 6'b000000;
    else if (stallreq_mem) es = 6'b011111;
    else if (ex_req)       es = 6'b001111;
    else if (stallreq_id)  es = 6'b000111;
    else if (stallreq_if)  es = 6'b000011;
    else                   es = 6'b000000;
    ed = m_op && m_owed == 0 && !stallreq_mem && !excp_valid;
    sat_small = (m_perf > 15) ? 15 : m_perf;
    check("stall", stall, es);
    check("flush", flush, excp_valid);
    check("new_pc", new_pc, excp_valid ? excp_vector : 32'h0);
    check("mc_done", mc_done, ed);
    check("mc_busy", mc_busy, m_op);
    check("stall_cycles", stall_cycles, m_perf[31:0]);
    check("stall_cycles_sat", s_cycles, sat_small);
    if (es[0]) m_perf++;
    if (excp_valid) begin
      m_op = 0; m_owed = 0;
    end else if (!m_op) begin
      if (mc_start && mc_cycles != 0) begin
        m_op = 1; m_owed = int'(mc_cycles) - 1;
      end
    end else if (m_owed > 0) begin
      if (!stallreq_mem) m_owed--;
    end else if (!stallreq_mem) begin
      m_op = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_stall", stall, 6'b0);
    check("rst_flush", flush, 1'b0);
    check("rst_new_pc", new_pc, 32'h0);
    check("rst_mc_done", mc_done, 1'b0);
    check("rst_mc_busy", mc_busy, 1'b0);
    check("rst_stall_cycles", stall_cycles, 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    clear_inputs();
  endtask

  initial begin
    int ex_cnt;
    int done_cnt;
    clear_inputs();
    model_reset();
    #1;
    check("init_stall", stall, 6'b0);
    check("init_busy", mc_busy, 1'b0);
    check("init_cycles", stall_cycles, 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;

    // Plain 4-cycle multi-cycle op.
    mc_start = 1; mc_cycles = 6'd4;
    step();
    check("t2_first", smp_stall, 6'b001111);
    mc_start = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_hold", smp_stall, 6'b001111);
    end
    step();
    check("t2_end_stall", smp_stall, 6'b000000);
    check("t2_end_done", smp_done, 1'b1);
    check("t2_perf", stall_cycles, 32'd4);

    // Same op with two MEM-frozen cycles in the middle.
    apply_reset();
    ex_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      mc_start = (i == 0); mc_cycles = 6'd4;
      stallreq_mem = (i == 2 || i == 3);
      step();
      if (i == 2 || i == 3) check("t3_mem", smp_stall, 6'b011111);
      if (smp_stall[3]) ex_cnt++;
      if (smp_done) done_cnt++;
    end
    check("t3_ex_cycles", ex_cnt, 6);
    check("t3_done_once", done_cnt, 1);

    // Request priority among stages.
    clear_inputs();
    stallreq_id = 1; stallreq_if = 1;
    step();
    check("t4_id_if", smp_stall, 6'b000111);
    stallreq_mem = 1;
    step();
    check("t4_mem", smp_stall, 6'b011111);

    // Exception mid-op aborts it.
    apply_reset();
    mc_start = 1; mc_cycles = 6'd4;
    step();
    mc_start = 0; excp_valid = 1; excp_vector = 32'h0000_0020;
    step();
    check("t5_flush", smp_flush, 1'b1);
    check("t5_pc", smp_pc, 32'h20);
    check("t5_stall", smp_stall, 6'b0);
    excp_valid = 0; excp_vector = 0;
    step();
    check("t5_no_done", smp_done, 1'b0);
    check("t5_idle", mc_busy, 1'b0);

    // Zero-length op is ignored.
    mc_start = 1; mc_cycles = 6'd0;
    step();
    check("t6_stall", smp_stall, 6'b0);
    check("t6_done", smp_done, 1'b0);
    check("t6_idle", mc_busy, 1'b0);

    // Async reset in the middle of an op with cnt=5 and active inputs.
    clear_inputs();
    mc_start = 1; mc_cycles = 6'd6;
    step();
    mc_start = 0;
    check("t1_busy", mc_busy, 1'b1);
    stallreq_mem = 1; excp_valid = 1; excp_vector = 32'hdead_beef;
    apply_reset();

    // Saturation of the narrow counter.
    stallreq_if = 1;
    for (int i = 0; i < 20; i++) step();
    check("sat_small", s_cycles, 4'hF);
    check("sat_wide", stall_cycles, 32'd20);

    // Random traffic.
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      stallreq_if  = ($urandom_range(0, 5) == 0);
      stallreq_id  = ($urandom_range(0, 7) == 0);
      stallreq_ex  = ($urandom_range(0, 9) == 0);
      stallreq_mem = ($urandom_range(0, 5) == 0);
      mc_start     = ($urandom_range(0, 4) == 0);
      mc_cycles    = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7));
      excp_valid   = ($urandom_range(0, 24) == 0);
      excp_vector  = $urandom;
      if (i % 700 == 699) apply_reset();
      else step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
